// File: rtl/latch_ctrl_pkg.sv
// Shared types for the latch write sequencer: FSM state encoding and the
// phase-counter width helper.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        ACK   = 3'd4
    } state_t;

    // Width of a down-counter that must reach the longest phase length minus one.
    function automatic int phase_cnt_width(input int s, input int p, input int h);
        int m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot winner selection among requesters. Round-robin with a registered
// pointer when LATCH_WR_SEQ_RR_EN is defined, otherwise lowest index wins.
module rr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_en,
    output logic [N_REQ-1:0] win
);

`ifdef LATCH_WR_SEQ_RR_EN
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;

    // Search begins at the pointer and wraps once around all requesters.
    always_comb begin
        int  idx;
        logic found;
        win     = '0;
        win_idx = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                win_idx  = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (grant_en) begin
            ptr <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`else
    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                win[i] = 1'b1;
            end
        end
    end

    logic unused_rr;
    assign unused_rr = ^{clk, reset, grant_en};
`endif

endmodule

// File: rtl/latch_wr_sequencer.sv
// Arbitrates requesters onto a shared latch bank and sequences setup, enable
// pulse and hold phases. Build option: LATCH_WR_SEQ_RR_EN (round-robin).
module latch_wr_sequencer
    import latch_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int N_LAT     = 4,
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int AW        = $clog2(N_LAT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic                wr_err,
    output logic [N_LAT-1:0]    lat_en,
    output logic [DW-1:0]       lat_d,
    output logic                busy,
    output state_t              dbg_state
);

    localparam int CW = phase_cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [AW:0] LAT_LIM = N_LAT[AW:0];

    // Handshake: a requester raises req (level) with addr/data valid; the
    // sequencer samples them only on the grant edge, holds gnt for the whole
    // write and returns a single-cycle ack; req need not stay high after gnt.

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [AW-1:0]    addr_q, addr_n;
    logic             err_q, err_n;
    logic [N_REQ-1:0] gnt_n, ack_n;
    logic             wr_err_n;
    logic [N_LAT-1:0] lat_en_n;
    logic [DW-1:0]    lat_d_n;
    logic [N_REQ-1:0] win;
    logic             grant_en;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant_en (grant_en),
        .win      (win)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_n   = addr_q;
        err_n    = err_q;
        gnt_n    = gnt;
        lat_d_n  = lat_d;
        lat_en_n = '0;
        ack_n    = '0;
        wr_err_n = 1'b0;
        grant_en = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_en = 1'b1;
                    gnt_n    = win;
                    addr_n   = sel_addr;
                    lat_d_n  = sel_data;
                    err_n    = ({1'b0, sel_addr} >= LAT_LIM);
                    cnt_n    = CW'(SETUP_CYC - 1);
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    cnt_n    = CW'(PULSE_CYC - 1);
                    lat_en_n = err_q ? '0 : (N_LAT'(1) << addr_q);
                    state_n  = PULSE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    cnt_n   = CW'(HOLD_CYC - 1);
                    state_n = HOLD;
                end else begin
                    cnt_n    = cnt - CW'(1);
                    lat_en_n = lat_en;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    ack_n    = gnt;
                    wr_err_n = err_q;
                    state_n  = ACK;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ACK: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Every output is registered so lat_en cannot glitch on the latch array.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
            gnt    <= '0;
            ack    <= '0;
            wr_err <= 1'b0;
            lat_en <= '0;
            lat_d  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            err_q  <= err_n;
            gnt    <= gnt_n;
            ack    <= ack_n;
            wr_err <= wr_err_n;
            lat_en <= lat_en_n;
            lat_d  <= lat_d_n;
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_latch_wr_sequencer.sv
// Bench for latch_wr_sequencer: transaction-level timing model checked every
// cycle, end-to-end latch bank scoreboard, plus directed literal checks.
module tb_latch_wr_sequencer;
    import latch_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int S  = 1;
    localparam int P  = 2;
    localparam int H  = 1;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt, ack;
    logic            wr_err, busy;
    logic [L-1:0]    lat_en;
    logic [DW-1:0]   lat_d;
    state_t          dbg_state;

    // Second instance with an unused address code to reach the error path.
    logic [1:0]  req3;
    logic [3:0]  req_addr3;
    logic [15:0] req_data3;
    logic [1:0]  gnt3, ack3;
    logic        wr_err3, busy3;
    logic [2:0]  lat_en3;
    logic [7:0]  lat_d3;
    state_t      dbg_state3;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    latch_wr_sequencer #(.N_REQ(N), .N_LAT(L), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .ack(ack), .wr_err(wr_err), .lat_en(lat_en), .lat_d(lat_d),
        .busy(busy), .dbg_state(dbg_state)
    );

    latch_wr_sequencer #(.N_REQ(2), .N_LAT(3), .DW(8)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .req_addr(req_addr3), .req_data(req_data3),
        .gnt(gnt3), .ack(ack3), .wr_err(wr_err3), .lat_en(lat_en3), .lat_d(lat_d3),
        .busy(busy3), .dbg_state(dbg_state3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // A write occupies k = 0..S+P+H cycles after its grant edge.
    bit            m_active = 1'b0;
    int            m_k = 0;
    int            m_win = 0;
    int            m_ptr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_lat_d = '0;
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0] bank [L];
    bit run_cmp = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_active = 1'b0;
            m_k      = 0;
            m_lat_d  = '0;
            m_ptr    = 0;
            exp_q.delete();
        end else if (m_active) begin
            m_k++;
            if (m_k > S + P + H) m_active = 1'b0;
        end else if (|req) begin
            m_win    = pick(req, m_ptr);
            m_addr   = req_addr[m_win*AW +: AW];
            m_data   = req_data[m_win*DW +: DW];
            m_lat_d  = m_data;
            m_active = 1'b1;
            m_k      = 0;
`ifdef LATCH_WR_SEQ_RR_EN
            m_ptr = (m_win + 1) % N;
`endif
            exp_q.push_back({m_addr, m_data});
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [N-1:0]     e_gnt, e_ack;
    logic [L-1:0]     e_len;
    logic [AW+DW-1:0] sb_item;

    always @(negedge clk) begin
        if (run_cmp) begin
            e_gnt = m_active ? N'(1) << m_win : '0;
            e_ack = (m_active && m_k == S + P + H) ? N'(1) << m_win : '0;
            e_len = (m_active && m_k >= S && m_k < S + P) ? L'(1) << m_addr : '0;
            check("gnt", gnt, e_gnt);
            check("ack", ack, e_ack);
            check("wr_err", wr_err, 0);
            check("lat_en", lat_en, e_len);
            check("lat_d", lat_d, m_lat_d);
            check("busy", busy, m_active);
            for (int j = 0; j < L; j++) if (lat_en[j]) bank[j] = lat_d;
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 0, 1);
                end else begin
                    sb_item = exp_q.pop_front();
                    check("bank", bank[sb_item[AW+DW-1:DW]], sb_item[DW-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] exp_order [5];

    initial begin
        for (int j = 0; j < L; j++) bank[j] = '0;
        reset = 1'b0; req = 4'b1111; req_addr = '0; req_data = '0;
        req3 = '0; req_addr3 = '0; req_data3 = '0;
        run_cmp = 1'b1;

        // Reset held with all requests up.
        step(3);
        check("rst_gnt", gnt, 0);   check("rst_busy", busy, 0);
        check("rst_lat_en", lat_en, 0); check("rst_lat_d", lat_d, 0);
        check("rst_ack", ack, 0);   check("rst_state", dbg_state, IDLE);
        reset = 1'b1;
        step(1);
        check("first_gnt", gnt, 4'b0001);
        req = '0;
        step(5);

        // Single write: requester 2, address 3, data A5.
        req = 4'b0100; req_addr = 8'b0011_0000; req_data = 32'h00A5_0000;
        step(1);
        check("sw_lat_d", lat_d, 8'hA5); check("sw_gnt", gnt, 4'b0100);
        check("sw_len0", lat_en, 0);
        req = '0; req_data = '0;
        step(1); check("sw_len1", lat_en, 4'b1000);
        step(1); check("sw_len2", lat_en, 4'b1000);
        step(1); check("sw_len3", lat_en, 0); check("sw_hold_d", lat_d, 8'hA5);
        step(1); check("sw_ack", ack, 4'b0100);
        step(1); check("sw_ack_end", ack, 0); check("sw_idle", busy, 0);

        // Held requests: arbitration order over five grants.
        reset = 1'b0; step(1); reset = 1'b1;
`ifdef LATCH_WR_SEQ_RR_EN
        req = 4'b1111;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        req = 4'b1010;
        exp_order = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
        step(1);
        for (int g = 0; g < 5; g++) begin
            check("arb_order", gnt, exp_order[g]);
            step(6);
        end
        req = '0;
        step(6);

        // Out-of-range address on the three-latch instance.
        req3 = 2'b01; req_addr3 = 4'b0011; req_data3 = 16'h003C;
        step(1); check("err_gnt", gnt3, 2'b01); check("err_lat_d", lat_d3, 8'h3C);
        req3 = '0;
        step(1); check("err_len1", lat_en3, 0);
        step(1); check("err_len2", lat_en3, 0);
        step(1); check("err_noack", ack3, 0);
        step(1); check("err_ack", ack3, 2'b01); check("err_flag", wr_err3, 1);
        step(1); check("err_ack_end", ack3, 0); check("err_flag_end", wr_err3, 0);
        req3 = 2'b10; req_addr3 = 4'b1000; req_data3 = 16'hFE00;
        step(1); check("ok3_gnt", gnt3, 2'b10); check("ok3_lat_d", lat_d3, 8'hFE);
        req3 = '0;
        step(1); check("ok3_len", lat_en3, 3'b100);
        step(3); check("ok3_ack", ack3, 2'b10); check("ok3_noerr", wr_err3, 0);
        step(2);

        // Reset during the enable pulse aborts the write with no ack.
        req = 4'b0001; req_addr = 8'h01; req_data = 32'h0000_005A;
        step(1);
        req = '0;
        step(1); check("ab_len", lat_en, 4'b0010);
        reset = 1'b0;
        step(1);
        check("ab_len_rst", lat_en, 0); check("ab_gnt", gnt, 0);
        check("ab_busy", busy, 0);      check("ab_lat_d", lat_d, 0);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(1); check("ab_noack", ack, 0);
        end
        req = 4'b1000; req_addr = 8'h00; req_data = 32'h7700_0000;
        step(1); check("ab_new_gnt", gnt, 4'b1000);
        req = '0;
        step(4); check("ab_new_ack", ack, 4'b1000); check("ab_new_d", lat_d, 8'h77);
        step(2);

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            req_addr = N*AW'($urandom);
            req_data = $urandom;
            step(1);
        end
        req = '0;
        reset = 1'b1;
        step(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
